// File: rtl/pc_gen_btb.sv
// Fetch PC generator with a direct-mapped branch target buffer and 2-bit counters.
// Control flow resolves in E; a misprediction flushes D/E and redirects fetch.
module pc_gen_btb #(
   parameter int unsigned      WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int unsigned      BTB_DEPTH    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             StallF,
   input  logic             ValidE,
   input  logic [2:0]       PCSrcE,
   input  logic             ZeroE,
   input  logic [WIDTH-1:0] PCE,
   input  logic [WIDTH-1:0] PCTargetE,
   input  logic [WIDTH-1:0] ALUResultE,
   input  logic             PredTakenE,
   input  logic [WIDTH-1:0] PredTargetE,
   output logic [WIDTH-1:0] PCF,
   output logic [WIDTH-1:0] PCPlus4F,
   output logic             PredTakenF,
   output logic [WIDTH-1:0] PredTargetF,
   output logic             FlushDE,
   output logic             MisalignE
);

   localparam int unsigned      IDX  = $clog2(BTB_DEPTH);
   localparam int unsigned      TAGW = WIDTH - IDX - 2;
   localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

   typedef enum logic [2:0] {
      CF_NONE = 3'b000,
      CF_JAL  = 3'b001,
      CF_JALR = 3'b010,
      CF_BNZ  = 3'b100,
      CF_BZ   = 3'b101
   } cf_e;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic             btb_valid_q [BTB_DEPTH];
   logic             btb_valid_d [BTB_DEPTH];
   logic [1:0]       btb_cnt_q   [BTB_DEPTH];
   logic [1:0]       btb_cnt_d   [BTB_DEPTH];
   logic [TAGW-1:0]  btb_tag_q   [BTB_DEPTH];
   logic [TAGW-1:0]  btb_tag_d   [BTB_DEPTH];
   logic [WIDTH-1:0] btb_tgt_q   [BTB_DEPTH];
   logic [WIDTH-1:0] btb_tgt_d   [BTB_DEPTH];

   logic             taken_e, is_cf_e, is_jump_e;
   logic [WIDTH-1:0] target_e, redirect_e;
   logic [IDX-1:0]   f_idx, u_idx;
   logic [TAGW-1:0]  f_tag, u_tag;
   logic             f_hit, u_hit;

   // E-stage resolution; unlisted codes behave as no control flow
   always_comb begin
      taken_e   = 1'b0;
      is_cf_e   = 1'b0;
      is_jump_e = 1'b0;
      case (PCSrcE)
         CF_JAL, CF_JALR: begin
            taken_e   = 1'b1;
            is_cf_e   = 1'b1;
            is_jump_e = 1'b1;
         end
         CF_BZ: begin
            taken_e = ZeroE;
            is_cf_e = 1'b1;
         end
         CF_BNZ: begin
            taken_e = ~ZeroE;
            is_cf_e = 1'b1;
         end
         default: ;
      endcase
      target_e   = (PCSrcE == CF_JALR) ? {ALUResultE[WIDTH-1:1], 1'b0} : PCTargetE;
      redirect_e = taken_e ? target_e : PCE + FOUR;
      FlushDE    = ValidE & ((taken_e != PredTakenE) | (taken_e & (PredTargetE != target_e)));
      MisalignE  = ValidE & taken_e & target_e[1];
   end

   always_comb begin
      PCF         = pc_q;
      PCPlus4F    = pc_q + FOUR;
      f_idx       = pc_q[IDX+1:2];
      f_tag       = pc_q[WIDTH-1:IDX+2];
      f_hit       = btb_valid_q[f_idx] & (btb_tag_q[f_idx] == f_tag);
      PredTakenF  = f_hit & btb_cnt_q[f_idx][1];
      PredTargetF = f_hit ? btb_tgt_q[f_idx] : PCPlus4F;
   end

   always_comb begin
      pc_d = PCPlus4F;
      if (FlushDE)         pc_d = redirect_e;
      else if (StallF)     pc_d = pc_q;
      else if (PredTakenF) pc_d = PredTargetF;
   end

   // Training is indexed by PCE and ignores StallF; lookup reads the registered copy
   always_comb begin
      btb_valid_d = btb_valid_q;
      btb_cnt_d   = btb_cnt_q;
      btb_tag_d   = btb_tag_q;
      btb_tgt_d   = btb_tgt_q;
      u_idx       = PCE[IDX+1:2];
      u_tag       = PCE[WIDTH-1:IDX+2];
      u_hit       = btb_valid_q[u_idx] & (btb_tag_q[u_idx] == u_tag);
      if (ValidE && is_cf_e) begin
         if (taken_e) begin
            btb_tgt_d[u_idx] = target_e;
            if (u_hit) begin
               if (btb_cnt_q[u_idx] != 2'b11) btb_cnt_d[u_idx] = btb_cnt_q[u_idx] + 2'd1;
            end else begin
               btb_valid_d[u_idx] = 1'b1;
               btb_tag_d[u_idx]   = u_tag;
               btb_cnt_d[u_idx]   = is_jump_e ? 2'b11 : 2'b10;
            end
         end else if (u_hit && btb_cnt_q[u_idx] != 2'b00) begin
            btb_cnt_d[u_idx] = btb_cnt_q[u_idx] - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q        <= RESET_VECTOR;
         btb_valid_q <= '{default: 1'b0};
         btb_cnt_q   <= '{default: 2'b01};
      end else begin
         pc_q        <= pc_d;
         btb_valid_q <= btb_valid_d;
         btb_cnt_q   <= btb_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      btb_tag_q <= btb_tag_d;
      btb_tgt_q <= btb_tgt_d;
   end

endmodule
